instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the ID-stage decoder: accepts symbolic instruction commands (op + fields) over a valid/ready port.
//  Packs each command into a 32-bit MIPS word and writes it sequentially into instruction memory.
//  Used by the testbench and boot path to load programs into the pipelined CPU. Emits only words the decoder recognises.
// PARAMETERS
//  DEPTH   64               instruction memory words writable (power of 2, >=2)
//  ADDR_W  $clog2(DEPTH)    imem word-address width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous active-high reset
//  start        in   1        pulse: begin a new program load (honoured in IDLE and DONE only)
//  cmd_valid    in   1        command present
//  cmd_ready    out  1        command accepted on clk edge when valid&ready
//  cmd_op       in   5        symbolic op (enum below)
//  cmd_rs/rt/rd in   5 each   register fields
//  cmd_shamt    in   5        shift amount
//  cmd_imm      in   16       immediate / branch offset
//  cmd_target   in   26       jump target
//  imem_we      out  1        write strobe, one cycle per word
//  imem_addr    out  ADDR_W   word address
//  imem_wdata   out  32       encoded instruction
//  busy         out  1        state==LOAD
//  done         out  1        state==DONE
//  prog_len     out  ADDR_W+1 words written this load
//  full         out  1        load ended because DEPTH words were written
//  err_illegal  out  1        sticky: an undefined cmd_op was accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, write pointer 0. Reset overrides everything, including a pending write (imem_we=0 next cycle).
//  FSM: IDLE -start-> LOAD (clears ptr, prog_len, full, err_illegal).
//   LOAD -accept END-> DONE. LOAD -accept making count==DEPTH-> DONE with full=1. DONE -start-> LOAD.
//   start is ignored in LOAD.
//  cmd_ready = (state==LOAD) && (count<DEPTH); registered-state combinational, no dependency on cmd_valid.
//  Latency: word accepted at edge N -> imem_we=1, addr=ptr, wdata=word during cycle N..N+1. Memory writes at edge N+1.
//   Throughput: 1 word/cycle, back-to-back accepts allowed. ptr and prog_len increment at accept edge.
//  Last write is still issued in the first DONE cycle (pipeline reg independent of state).
//  Encoding (unused fields forced 0):
//   0x00-07 ADD,ADDU,SUB,SUBU,AND,OR,XOR,NOR: {6'b0,rs,rt,rd,5'b0,3'b100,op[2:0]}
//   0x08 SLT funct 101010; 0x09 SLTU funct 101011 (R-format as above)
//   0x0A-10 ADDI,ADDIU,SLTI,SLTIU,ANDI,ORI,XORI: {3'b001,(op-0x0A)[2:0],rs,rt,imm}
//   0x11 SLL {6'b0,5'b0,rt,rd,shamt,6'b000000}; 0x12 SRL same, funct 000010
//   0x13 LW {100011,rs,rt,imm}; 0x14 SW {101011,rs,rt,imm}
//   0x15 BEQ {000100,rs,rt,imm}; 0x16 BNE {000101,rs,rt,imm}
//   0x17 J {000010,target}; 0x18 NOP 32'h0
//   0x19 END: accepted, not written, ends load
//   0x1A-1F illegal: accepted, not written, count unchanged, err_illegal<=1
//  SLL with rd=0,rt=0,shamt=0 yields 32'h0; written as a normal word.
//  END accepted when count==DEPTH-1 with no prior overflow: DONE, full=0.
//  ptr never wraps: ready drops at count==DEPTH.
// STRUCTURE
//  defines.v: add the CMD_* op enum, OPC_*/FUNCT_* field constants, and `WORD_LEN for the encoder.
//  Sub-module instr_field_packer: purely combinational (op, fields) -> {word, is_write, is_end, is_illegal}.
//  Top holds the FSM, ptr/count, and the output pipeline register.
// TESTING
//  start, ADD rs1 rt2 rd3 -> we@addr0, wdata 0x00221820, prog_len 1.
//  ADDI rs0 rt1 imm5, SLL rt1 rd2 sh4, LW rs2 rt3 imm8 back-to-back -> 0x20010005, 0x00011100, 0x8C430008 at addr 0,1,2 on consecutive cycles.
//  BNE rs1 rt2 imm FFFF, J target 0x10, END -> 0x1422FFFF, 0x08000010; done=1, prog_len 2, full=0.
//  DEPTH=4: 4 NOPs w/o END -> ready low after 4th accept, done=1, full=1, prog_len 4, extra valid stalls.
//  op 0x1F mid-stream -> no write, err_illegal=1 sticky until next start, next word gets next addr.
//  rst asserted the cycle after an accept -> imem_we 0, all outputs 0, IDLE; start restarts at addr 0.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: symbolic command ops,
// MIPS opcode/funct fields, FSM state codes and the packer result bundle.
package instr_encoder_loader_pkg;

   localparam int WORD_LEN = 32;

   typedef enum logic [4:0] {
      CMD_ADD   = 5'h00,
      CMD_ADDU  = 5'h01,
      CMD_SUB   = 5'h02,
      CMD_SUBU  = 5'h03,
      CMD_AND   = 5'h04,
      CMD_OR    = 5'h05,
      CMD_XOR   = 5'h06,
      CMD_NOR   = 5'h07,
      CMD_SLT   = 5'h08,
      CMD_SLTU  = 5'h09,
      CMD_ADDI  = 5'h0A,
      CMD_ADDIU = 5'h0B,
      CMD_SLTI  = 5'h0C,
      CMD_SLTIU = 5'h0D,
      CMD_ANDI  = 5'h0E,
      CMD_ORI   = 5'h0F,
      CMD_XORI  = 5'h10,
      CMD_SLL   = 5'h11,
      CMD_SRL   = 5'h12,
      CMD_LW    = 5'h13,
      CMD_SW    = 5'h14,
      CMD_BEQ   = 5'h15,
      CMD_BNE   = 5'h16,
      CMD_J     = 5'h17,
      CMD_NOP   = 5'h18,
      CMD_END   = 5'h19
   } cmd_op_e;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_J        = 6'b000010;
   localparam logic [5:0] OPC_BEQ      = 6'b000100;
   localparam logic [5:0] OPC_BNE      = 6'b000101;
   localparam logic [5:0] OPC_LW       = 6'b100011;
   localparam logic [5:0] OPC_SW       = 6'b101011;
   localparam logic [2:0] OPC_IMM_BASE = 3'b001;

   localparam logic [5:0] FUNCT_SLL      = 6'b000000;
   localparam logic [5:0] FUNCT_SRL      = 6'b000010;
   localparam logic [5:0] FUNCT_SLT      = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU     = 6'b101011;
   localparam logic [2:0] FUNCT_ALU_BASE = 3'b100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic [WORD_LEN-1:0] word;
      logic                is_write;
      logic                is_end;
      logic                is_illegal;
   } pack_res_t;

endpackage

// File: rtl/instr_encoder_loader_field_packer.sv
// Purely combinational packer: symbolic op plus fields -> 32-bit MIPS word and
// classification flags (word to write, end-of-program marker, undefined op).
module instr_field_packer
   import instr_encoder_loader_pkg::*;
(
   input  logic [4:0]  i_op,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output pack_res_t   o_res
);

   // Immediate ALU opcodes run 001000..001110 in the same order as ADDI..XORI.
   logic [2:0] w_imm_sel;
   assign w_imm_sel = i_op[2:0] - 3'd2;

   always_comb begin
      o_res = '0;
      o_res.is_write = 1'b1;
      case (i_op)
         CMD_ADD, CMD_ADDU, CMD_SUB, CMD_SUBU,
         CMD_AND, CMD_OR, CMD_XOR, CMD_NOR:
            o_res.word = {OPC_SPECIAL, i_rs, i_rt, i_rd, 5'b0, FUNCT_ALU_BASE, i_op[2:0]};
         CMD_SLT:
            o_res.word = {OPC_SPECIAL, i_rs, i_rt, i_rd, 5'b0, FUNCT_SLT};
         CMD_SLTU:
            o_res.word = {OPC_SPECIAL, i_rs, i_rt, i_rd, 5'b0, FUNCT_SLTU};
         CMD_ADDI, CMD_ADDIU, CMD_SLTI, CMD_SLTIU,
         CMD_ANDI, CMD_ORI, CMD_XORI:
            o_res.word = {OPC_IMM_BASE, w_imm_sel, i_rs, i_rt, i_imm};
         CMD_SLL:
            o_res.word = {OPC_SPECIAL, 5'b0, i_rt, i_rd, i_shamt, FUNCT_SLL};
         CMD_SRL:
            o_res.word = {OPC_SPECIAL, 5'b0, i_rt, i_rd, i_shamt, FUNCT_SRL};
         CMD_LW:
            o_res.word = {OPC_LW, i_rs, i_rt, i_imm};
         CMD_SW:
            o_res.word = {OPC_SW, i_rs, i_rt, i_imm};
         CMD_BEQ:
            o_res.word = {OPC_BEQ, i_rs, i_rt, i_imm};
         CMD_BNE:
            o_res.word = {OPC_BNE, i_rs, i_rt, i_imm};
         CMD_J:
            o_res.word = {OPC_J, i_target};
         CMD_NOP:
            o_res.word = '0;
         CMD_END: begin
            o_res.is_write = 1'b0;
            o_res.is_end   = 1'b1;
         end
         default: begin
            o_res.is_write   = 1'b0;
            o_res.is_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic commands, packs them into MIPS words and
// streams them into instruction memory through a one-stage write register.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [4:0]          i_cmd_op,
   input  logic [4:0]          i_cmd_rs,
   input  logic [4:0]          i_cmd_rt,
   input  logic [4:0]          i_cmd_rd,
   input  logic [4:0]          i_cmd_shamt,
   input  logic [15:0]         i_cmd_imm,
   input  logic [25:0]         i_cmd_target,
   output logic                o_imem_we,
   output logic [ADDR_W-1:0]   o_imem_addr,
   output logic [WORD_LEN-1:0] o_imem_wdata,
   output logic                o_busy,
   output logic                o_done,
   output logic [ADDR_W:0]     o_prog_len,
   output logic                o_full,
   output logic                o_err_illegal,
   output logic [1:0]          o_dbg_state
);

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

   logic [1:0]          r_state;
   logic [ADDR_W:0]     r_count;
   logic                r_full;
   logic                r_err;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_LEN-1:0] r_wdata;

   pack_res_t w_res;
   logic      w_ready;
   logic      w_accept;

   instr_field_packer u_packer (
      .i_op     (i_cmd_op),
      .i_rs     (i_cmd_rs),
      .i_rt     (i_cmd_rt),
      .i_rd     (i_cmd_rd),
      .i_shamt  (i_cmd_shamt),
      .i_imm    (i_cmd_imm),
      .i_target (i_cmd_target),
      .o_res    (w_res)
   );

   // Handshake: a command transfers on a rising edge where valid and ready are
   // both high; ready depends on registered state only, never on valid.
   assign w_ready  = (r_state == ST_LOAD) && (r_count < C_DEPTH);
   assign w_accept = i_cmd_valid && w_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_state <= ST_LOAD;
                  r_count <= '0;
                  r_full  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  if (w_res.is_write) begin
                     r_count <= r_count + 1'b1;
                     if (r_count == C_DEPTH - 1'b1) begin
                        r_state <= ST_DONE;
                        r_full  <= 1'b1;
                     end
                  end else if (w_res.is_end) begin
                     r_state <= ST_DONE;
                  end else if (w_res.is_illegal) begin
                     r_err <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write stage runs regardless of state so the final word still lands in DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_accept && w_res.is_write;
         if (w_accept && w_res.is_write) begin
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_res.word;
         end
      end
   end

   assign o_cmd_ready   = w_ready;
   assign o_imem_we     = r_we;
   assign o_imem_addr   = r_addr;
   assign o_imem_wdata  = r_wdata;
   assign o_busy        = (r_state == ST_LOAD);
   assign o_done        = (r_state == ST_DONE);
   assign o_prog_len    = r_count;
   assign o_full        = r_full;
   assign o_err_illegal = r_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a small memory so the full
// condition is reachable; imem writes are checked against an expected queue.
module tb_instr_encoder_loader;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic              i_cmd_valid = 1'b0;
   logic              o_cmd_ready;
   logic [4:0]        i_cmd_op = '0;
   logic [4:0]        i_cmd_rs = '0;
   logic [4:0]        i_cmd_rt = '0;
   logic [4:0]        i_cmd_rd = '0;
   logic [4:0]        i_cmd_shamt = '0;
   logic [15:0]       i_cmd_imm = '0;
   logic [25:0]       i_cmd_target = '0;
   logic              o_imem_we;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [31:0]       o_imem_wdata;
   logic              o_busy;
   logic              o_done;
   logic [ADDR_W:0]   o_prog_len;
   logic              o_full;
   logic              o_err_illegal;
   logic [1:0]        o_dbg_state;

   int total = 0;
   int bad   = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [ADDR_W-1:0]  exp_ptr = '0;

   instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_op      (i_cmd_op),
      .i_cmd_rs      (i_cmd_rs),
      .i_cmd_rt      (i_cmd_rt),
      .i_cmd_rd      (i_cmd_rd),
      .i_cmd_shamt   (i_cmd_shamt),
      .i_cmd_imm     (i_cmd_imm),
      .i_cmd_target  (i_cmd_target),
      .o_imem_we     (o_imem_we),
      .o_imem_addr   (o_imem_addr),
      .o_imem_wdata  (o_imem_wdata),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_prog_len    (o_prog_len),
      .o_full        (o_full),
      .o_err_illegal (o_err_illegal),
      .o_dbg_state   (o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoding: bit 32 set when the op produces a memory word.
   function automatic logic [32:0] model(input logic [4:0] op, input logic [4:0] rs, rt, rd, sh,
                                         input logic [15:0] imm, input logic [25:0] tgt);
      logic [5:0] alu_funct[10];
      logic [5:0] imm_opc[7];
      alu_funct = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      imm_opc   = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
      if (op <= 5'h09) return {1'b1, 6'h00, rs, rt, rd, 5'd0, alu_funct[op]};
      if (op <= 5'h10) return {1'b1, imm_opc[op - 5'h0A], rs, rt, imm};
      case (op)
         5'h11: return {1'b1, 11'd0, rt, rd, sh, 6'h00};
         5'h12: return {1'b1, 11'd0, rt, rd, sh, 6'h02};
         5'h13: return {1'b1, 6'h23, rs, rt, imm};
         5'h14: return {1'b1, 6'h2B, rs, rt, imm};
         5'h15: return {1'b1, 6'h04, rs, rt, imm};
         5'h16: return {1'b1, 6'h05, rs, rt, imm};
         5'h17: return {1'b1, 6'h02, tgt};
         5'h18: return {1'b1, 32'h0};
         default: return 33'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      exp_ptr = '0;
   endtask

   task automatic send(input logic [4:0] op, input logic [4:0] rs, rt, rd, sh,
                       input logic [15:0] imm, input logic [25:0] tgt);
      int n;
      logic [32:0] m;
      i_cmd_op = op; i_cmd_rs = rs; i_cmd_rt = rt; i_cmd_rd = rd;
      i_cmd_shamt = sh; i_cmd_imm = imm; i_cmd_target = tgt;
      i_cmd_valid = 1'b1;
      n = 0;
      while (!o_cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (!o_cmd_ready) begin
         check("send_timeout", 64'd0, 64'd1);
         i_cmd_valid = 1'b0;
         return;
      end
      m = model(op, rs, rt, rd, sh, imm, tgt);
      if (m[32]) begin
         exp_q.push_back({exp_ptr, m[31:0]});
         exp_ptr++;
      end
      tick();
      i_cmd_valid = 1'b0;
   endtask

   // Scoreboard: every observed write must match the oldest expected entry.
   always @(negedge clk) begin
      if (o_imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {o_imem_addr, o_imem_wdata}, 64'd0);
         end else begin
            logic [ADDR_W+31:0] e;
            e = exp_q.pop_front();
            check("imem_write", {o_imem_addr, o_imem_wdata}, e);
         end
      end
   end

   initial begin
      repeat (3) tick();
      check("rst_we",    o_imem_we, 0);
      check("rst_ready", o_cmd_ready, 0);
      check("rst_state", {o_busy, o_done, o_full, o_err_illegal, o_prog_len, o_imem_addr, o_imem_wdata}, 0);
      check("rst_dbg",   o_dbg_state, 0);
      i_rst = 1'b0;
      tick();
      check("idle_ignores_valid_ready", o_cmd_ready, 0);

      // Load 1: single ADD
      pulse_start();
      check("load_busy", o_busy, 1);
      check("load_ready", o_cmd_ready, 1);
      send(5'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      check("add_prog_len", o_prog_len, 1);
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("l1_done", o_done, 1);

      // Load 2: back-to-back, END at count==DEPTH-1
      pulse_start();
      send(5'h0A, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0);
      send(5'h11, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
      send(5'h13, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0008, 26'h0);
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("l2_done", o_done, 1);
      check("l2_prog_len", o_prog_len, 3);
      check("l2_end_not_full", o_full, 0);

      // Load 3: BNE, J, END
      pulse_start();
      send(5'h16, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
      send(5'h17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("l3_done", o_done, 1);
      check("l3_prog_len", o_prog_len, 2);
      check("l3_full", o_full, 0);

      // Load 4: fill memory without END
      pulse_start();
      for (int i = 0; i < DEPTH; i++) send(5'h18, 0, 0, 0, 0, 16'h0, 26'h0);
      check("full_ready", o_cmd_ready, 0);
      check("full_done", o_done, 1);
      check("full_flag", o_full, 1);
      check("full_prog_len", o_prog_len, DEPTH);
      i_cmd_valid = 1'b1;
      i_cmd_op = 5'h18;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_stall", o_cmd_ready, 0);
      end
      i_cmd_valid = 1'b0;
      check("full_len_hold", o_prog_len, DEPTH);

      // Load 5: illegal op mid-stream, start ignored in LOAD
      pulse_start();
      check("restart_clears_full", o_full, 0);
      check("restart_len", o_prog_len, 0);
      send(5'h00, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
      send(5'h1F, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0);
      check("illegal_err", o_err_illegal, 1);
      check("illegal_len", o_prog_len, 1);
      send(5'h02, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
      check("illegal_sticky", o_err_illegal, 1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("start_ignored_busy", o_busy, 1);
      check("start_ignored_len", o_prog_len, 2);
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("illegal_done_err", o_err_illegal, 1);
      check("illegal_done_len", o_prog_len, 2);
      pulse_start();
      check("start_clears_err", o_err_illegal, 0);

      // Reset overrides a pending accept
      send(5'h01, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0);
      i_cmd_op = 5'h02;
      i_cmd_valid = 1'b1;
      i_rst = 1'b1;
      tick();
      i_cmd_valid = 1'b0;
      check("rst_pending_we", o_imem_we, 0);
      check("rst_pending_state", {o_busy, o_done, o_full, o_err_illegal, o_prog_len, o_imem_addr, o_imem_wdata}, 0);
      check("rst_pending_dbg", o_dbg_state, 0);
      i_rst = 1'b0;
      tick();
      pulse_start();
      send(5'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("rst_restart_len", o_prog_len, 1);

      // Random legal words, then END
      pulse_start();
      for (int i = 0; i < DEPTH - 1; i++)
         send(5'($urandom_range(0, 24)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
              26'($urandom_range(0, 32'h3FFFFFF)));
      send(5'h19, 0, 0, 0, 0, 16'h0, 26'h0);
      check("rand_len", o_prog_len, DEPTH - 1);
      check("rand_done", o_done, 1);

      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
